// File: rtl/sub_32_pipe_2stage.sv
// Two-stage pipelined subtractor: stage 1 resolves the low half, stage 2 the high half
// using the registered low-half borrow. Valid/ready handshake; a stalled output freezes the pipe.
module sub_32_pipe_2stage #(
  parameter int SIZE = 32,
  localparam int HALF = SIZE / 2
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic [SIZE-1:0] a,
  input  logic [SIZE-1:0] b,
  input  logic            b_in,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [SIZE-1:0] diff,
  output logic            b_out,
  output logic            out_valid,
  input  logic            out_ready
);

  logic            en_s;
  logic [HALF:0]   low_s;
  logic [HALF:0]   high_s;

  logic            s1_valid_r;
  logic [HALF-1:0] s1_dl_r;
  logic            s1_bl_r;
  logic [HALF-1:0] s1_ah_r;
  logic [HALF-1:0] s1_bh_r;

  // The whole pipe advances only when the output slot is empty or being drained.
  assign en_s     = !(out_valid && !out_ready);
  assign in_ready = en_s;

  // Half-width subtractions; the extra MSB of each result is the borrow.
  always_comb begin
    low_s  = {1'b0, a[HALF-1:0]} - {1'b0, b[HALF-1:0]} - {{HALF{1'b0}}, b_in};
    high_s = {1'b0, s1_ah_r} - {1'b0, s1_bh_r} - {{HALF{1'b0}}, s1_bl_r};
  end

  // Stage 1: low-half difference and borrow, high-half operands carried forward.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_r <= 1'b0;
      s1_dl_r    <= {HALF{1'b0}};
      s1_bl_r    <= 1'b0;
      s1_ah_r    <= {HALF{1'b0}};
      s1_bh_r    <= {HALF{1'b0}};
    end else if (en_s) begin
      s1_valid_r <= in_valid;
      s1_dl_r    <= low_s[HALF-1:0];
      s1_bl_r    <= low_s[HALF];
      s1_ah_r    <= a[SIZE-1:HALF];
      s1_bh_r    <= b[SIZE-1:HALF];
    end
  end

  // Stage 2: high half resolved with the stage-1 borrow; final borrow is the output borrow.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      diff      <= {SIZE{1'b0}};
      b_out     <= 1'b0;
    end else if (en_s) begin
      out_valid <= s1_valid_r;
      diff      <= {high_s[HALF-1:0], s1_dl_r};
      b_out     <= high_s[HALF];
    end
  end

endmodule
